// File: rtl/seq_step_decoder.sv
// ---------------------------------------------------------------------------
// seq_step_decoder: decodes a 2-bit step-sequencer state stream into
// fwd/bwd/restart/error pulses, position and lap counts, and a lock flag.
// Optional history register enabled by SEQ_DEC_HIST_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_step_decoder #(
   parameter int POS_W     = 8,
   parameter int ERR_LIMIT = 3
) (
   input  logic             iclk,
   input  logic             irst,
   input  logic             ivalid,
   input  logic [1:0]       ivalor,
   input  logic             iclr,
   output logic             ofwd,
   output logic             obwd,
   output logic             orestart,
   output logic             oerr,
   output logic             olock,
   output logic [POS_W-1:0] oposicion,
   output logic [POS_W-1:0] ovueltas,
   output logic [7:0]       ohist
);

   typedef enum logic [0:0] {
      ST_UNSYNC = 1'b0,
      ST_TRACK  = 1'b1
   } state_t;

   localparam logic [3:0]       C_ERR_LIMIT = 4'(ERR_LIMIT);
   localparam logic [POS_W-1:0] C_ONE       = POS_W'(1);

   state_t           state_q, state_d;
   logic [1:0]       prev_q, prev_d;
   logic [3:0]       errs_q, errs_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic [POS_W-1:0] laps_q, laps_d;
   logic             fwd_q, fwd_d;
   logic             bwd_q, bwd_d;
   logic             rstrt_q, rstrt_d;
   logic             err_q, err_d;

   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      errs_d  = errs_q;
      pos_d   = pos_q;
      laps_d  = laps_q;
      fwd_d   = 1'b0;
      bwd_d   = 1'b0;
      rstrt_d = 1'b0;
      err_d   = 1'b0;

      if (ivalid) begin
         prev_d = ivalor;
         errs_d = 4'd0;
         if (state_q == ST_UNSYNC) begin
            state_d = ST_TRACK;
         end else begin
            // Decode the transition {previous, current}
            case ({prev_q, ivalor})
               4'b0001, 4'b0110, 4'b1011: begin
                  fwd_d = 1'b1;
                  pos_d = pos_q + C_ONE;
               end
               4'b1100: begin
                  fwd_d  = 1'b1;
                  pos_d  = pos_q + C_ONE;
                  laps_d = laps_q + C_ONE;
               end
               4'b0100, 4'b1001, 4'b1110: begin
                  bwd_d = 1'b1;
                  pos_d = pos_q - C_ONE;
               end
               4'b1000: begin
                  rstrt_d = 1'b1;
                  pos_d   = '0;
               end
               4'b0010, 4'b0011, 4'b0111, 4'b1101: begin
                  err_d  = 1'b1;
                  errs_d = errs_q + 4'd1;
                  if (errs_q + 4'd1 == C_ERR_LIMIT) begin
                     state_d = ST_UNSYNC;
                     errs_d  = 4'd0;
                  end
               end
               default: begin
                  errs_d = 4'd0;
               end
            endcase
         end
      end

      // Clear overrides any concurrent step or wrap on the counters
      if (iclr) begin
         pos_d  = '0;
         laps_d = '0;
      end
   end

   always_ff @(posedge iclk) begin
      if (!irst) begin
         state_q <= ST_UNSYNC;
         prev_q  <= 2'd0;
         errs_q  <= 4'd0;
         pos_q   <= '0;
         laps_q  <= '0;
         fwd_q   <= 1'b0;
         bwd_q   <= 1'b0;
         rstrt_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         errs_q  <= errs_d;
         pos_q   <= pos_d;
         laps_q  <= laps_d;
         fwd_q   <= fwd_d;
         bwd_q   <= bwd_d;
         rstrt_q <= rstrt_d;
         err_q   <= err_d;
      end
   end

   assign ofwd      = fwd_q;
   assign obwd      = bwd_q;
   assign orestart  = rstrt_q;
   assign oerr      = err_q;
   assign olock     = (state_q == ST_TRACK);
   assign oposicion = pos_q;
   assign ovueltas  = laps_q;

`ifdef SEQ_DEC_HIST_EN
   logic [7:0] hist_q;

   always_ff @(posedge iclk) begin
      if (!irst) begin
         hist_q <= 8'd0;
      end else if (ivalid) begin
         hist_q <= {hist_q[5:0], ivalor};
      end
   end

   assign ohist = hist_q;
`else
   assign ohist = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_step_decoder.sv
// ---------------------------------------------------------------------------
// tb_seq_step_decoder: scoreboard bench for seq_step_decoder.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seq_step_decoder;

   localparam int ERR_LIMIT = 3;

   logic       iclk = 1'b0;
   logic       irst = 1'b0;
   logic       ivalid = 1'b0;
   logic [1:0] ivalor = 2'd0;
   logic       iclr = 1'b0;
   logic       ofwd, obwd, orestart, oerr, olock;
   logic [7:0] oposicion, ovueltas, ohist;

   seq_step_decoder #(.POS_W(8), .ERR_LIMIT(ERR_LIMIT)) dut (
      .iclk(iclk), .irst(irst), .ivalid(ivalid), .ivalor(ivalor), .iclr(iclr),
      .ofwd(ofwd), .obwd(obwd), .orestart(orestart), .oerr(oerr), .olock(olock),
      .oposicion(oposicion), .ovueltas(ovueltas), .ohist(ohist)
   );

   always #5 iclk = ~iclk;

   typedef struct packed {
      logic       fwd;
      logic       bwd;
      logic       rst;
      logic       err;
      logic       lock;
      logic [7:0] pos;
      logic [7:0] laps;
      logic [7:0] hist;
   } obs_t;

   obs_t sb[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model state
   bit         m_track;
   logic [1:0] m_prev;
   int         m_errs;
   logic [7:0] m_pos, m_laps, m_hist;

   function automatic obs_t sample();
      obs_t o;
      o = {ofwd, obwd, orestart, oerr, olock, oposicion, ovueltas, ohist};
      return o;
   endfunction

   // Drive one cycle, push the model's expected post-edge outputs
   task automatic drive(input logic rst_n, input logic v, input logic [1:0] val, input logic c);
      obs_t       e;
      logic [1:0] d;
      e = '0;
      irst = rst_n; ivalid = v; ivalor = val; iclr = c;
      if (!rst_n) begin
         m_track = 0; m_prev = 0; m_errs = 0; m_pos = 0; m_laps = 0; m_hist = 0;
      end else begin
         if (v) begin
`ifdef SEQ_DEC_HIST_EN
            m_hist = {m_hist[5:0], val};
`endif
            if (!m_track) begin
               m_track = 1; m_errs = 0;
            end else begin
               d = val - m_prev;
               if (d == 2'd0) begin
                  m_errs = 0;
               end else if (d == 2'd1) begin
                  e.fwd = 1; m_pos = m_pos + 8'd1; m_errs = 0;
                  if (val == 2'd0) m_laps = m_laps + 8'd1;
               end else if (d == 2'd3 && m_prev != 2'd0) begin
                  e.bwd = 1; m_pos = m_pos - 8'd1; m_errs = 0;
               end else if (m_prev == 2'd2 && val == 2'd0) begin
                  e.rst = 1; m_pos = 8'd0; m_errs = 0;
               end else begin
                  e.err = 1; m_errs = m_errs + 1;
                  if (m_errs == ERR_LIMIT) begin
                     m_track = 0; m_errs = 0;
                  end
               end
            end
            m_prev = val;
         end
         if (c) begin
            m_pos = 8'd0; m_laps = 8'd0;
         end
      end
      e.lock = m_track; e.pos = m_pos; e.laps = m_laps; e.hist = m_hist;
      sb.push_back(e);
      @(posedge iclk);
      #1;
   endtask

   task automatic test_reset();
      obs_t exp, got;
      drive(0, 1, 2'd3, 1);
      drive(0, 0, 2'd0, 0);
      exp = sb.pop_front(); exp = sb.pop_front(); got = sample();
      checks++;
      if (got !== exp || got !== obs_t'(0)) begin
         errors++; $display("FAIL reset_state got=%h want=%h", got, obs_t'(0));
      end
      drive(1, 1, 2'd2, 0);
      exp = sb.pop_front(); got = sample();
      checks++;
      if (got !== exp) begin
         errors++; $display("FAIL first_sample got=%h want=%h", got, exp);
      end
      checks++;
      if (olock !== 1'b1 || oposicion !== 8'd0 || {ofwd, obwd, orestart, oerr} !== 4'b0) begin
         errors++; $display("FAIL first_lock got lock=%b pos=%0d want lock=1 pos=0", olock, oposicion);
      end
   endtask

   task automatic test_fwd_lap();
      obs_t exp, got;
      int   seq[6] = '{0, 1, 2, 3, 0, 1};
      drive(0, 0, 2'd0, 0); void'(sb.pop_front());
      for (int i = 0; i < 6; i++) begin
         drive(1, 1, 2'(seq[i]), 0);
         exp = sb.pop_front(); got = sample();
         checks++;
         if (got !== exp) begin
            errors++; $display("FAIL fwd_lap[%0d] got=%h want=%h", i, got, exp);
         end
         if (i == 4) begin
            checks++;
            if (ovueltas !== 8'd1 || ofwd !== 1'b1) begin
               errors++; $display("FAIL lap_count got=%0d want=1", ovueltas);
            end
         end
      end
      checks++;
      if (oposicion !== 8'd5 || ovueltas !== 8'd1) begin
         errors++; $display("FAIL fwd_final got pos=%0d laps=%0d want pos=5 laps=1", oposicion, ovueltas);
      end
   endtask

   task automatic test_bwd_restart();
      obs_t exp, got;
      int   seq[8] = '{0, 1, 2, 3, 2, 1, 2, 0};
      drive(0, 0, 2'd0, 0); void'(sb.pop_front());
      for (int i = 0; i < 8; i++) begin
         drive(1, 1, 2'(seq[i]), 0);
         exp = sb.pop_front(); got = sample();
         checks++;
         if (got !== exp) begin
            errors++; $display("FAIL bwd_restart[%0d] got=%h want=%h", i, got, exp);
         end
      end
      checks++;
      if (orestart !== 1'b1 || oposicion !== 8'd0 || ofwd !== 1'b0) begin
         errors++; $display("FAIL restart_pulse got rs=%b pos=%0d want rs=1 pos=0", orestart, oposicion);
      end
   endtask

   task automatic test_err_limit();
      obs_t exp, got;
      int   seq[8] = '{0, 2, 0, 1, 3, 1, 3, 0};
      drive(0, 0, 2'd0, 0); void'(sb.pop_front());
      for (int i = 0; i < 8; i++) begin
         drive(1, 1, 2'(seq[i]), 0);
         exp = sb.pop_front(); got = sample();
         checks++;
         if (got !== exp) begin
            errors++; $display("FAIL err_limit[%0d] got=%h want=%h", i, got, exp);
         end
         if (i == 6) begin
            checks++;
            if (olock !== 1'b0 || oerr !== 1'b1) begin
               errors++; $display("FAIL unlock got lock=%b err=%b want lock=0 err=1", olock, oerr);
            end
         end
      end
      checks++;
      if (olock !== 1'b1 || {ofwd, obwd, orestart, oerr} !== 4'b0) begin
         errors++; $display("FAIL relock got lock=%b want lock=1 no pulse", olock);
      end
   endtask

   task automatic test_clear_wrap();
      obs_t exp, got;
      int   seq[5] = '{1, 0, 1, 2, 3};
      drive(0, 0, 2'd0, 0); void'(sb.pop_front());
      for (int i = 0; i < 5; i++) begin
         drive(1, 1, 2'(seq[i]), 0);
         exp = sb.pop_front(); got = sample();
         checks++;
         if (got !== exp) begin
            errors++; $display("FAIL clear_wrap[%0d] got=%h want=%h", i, got, exp);
         end
         if (i == 1) begin
            checks++;
            if (oposicion !== 8'hFF || obwd !== 1'b1) begin
               errors++; $display("FAIL pos_underflow got=%h want=ff", oposicion);
            end
         end
      end
      drive(1, 1, 2'd0, 1);
      exp = sb.pop_front(); got = sample();
      checks++;
      if (got !== exp || ofwd !== 1'b1 || oposicion !== 8'd0 || ovueltas !== 8'd0) begin
         errors++; $display("FAIL clear_collision got=%h want=%h", got, exp);
      end
   endtask

   task automatic test_gating_midreset();
      obs_t exp, got;
      drive(1, 1, 2'd1, 0);
      drive(1, 0, 2'd3, 0);
      drive(1, 0, 2'd0, 1);
      drive(1, 1, 2'd2, 0);
      for (int i = 0; i < 4; i++) begin
         exp = sb.pop_front();
         if (i == 3) begin
            got = sample();
            checks++;
            if (got !== exp || ofwd !== 1'b1 || oposicion !== 8'd1) begin
               errors++; $display("FAIL gated_prev got=%h want=%h", got, exp);
            end
         end
      end
      drive(1, 1, 2'd3, 0); void'(sb.pop_front());
      drive(0, 1, 2'd0, 0);
      exp = sb.pop_front(); got = sample();
      checks++;
      if (got !== exp || got !== obs_t'(0)) begin
         errors++; $display("FAIL midrun_reset got=%h want=0", got);
      end
   endtask

   task automatic test_back_to_back();
      obs_t exp, got;
      drive(0, 0, 2'd0, 0); void'(sb.pop_front());
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
               2'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0));
         exp = sb.pop_front(); got = sample();
         checks++;
         if (got !== exp || $countones({ofwd, obwd, orestart, oerr}) > 1) begin
            errors++; $display("FAIL back_to_back[%0d] got=%h want=%h", i, got, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fwd_lap();
      test_bwd_restart();
      test_err_limit();
      test_clear_wrap();
      test_gating_midreset();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
